// File: rtl/cb_io_filter_sched.sv
// cb_io_filter_sched: time-multiplexed debounce scheduler for CH_NUM IO inputs.
// One compare/increment datapath walks every channel once per sample tick;
// per-channel counters live in a register array. An Avalon-MM slave exposes
// configuration, filtered levels, edge flags and an overrun flag.
//
// Optional feature macro: CB_IO_FILTER_SCHED_IRQ_EN
//   defined   -> IRQ_MASK register and registered irq_o are present
//   undefined -> irq_o tied low, IRQ_MASK reads 0, flags remain pollable
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an enabled sample tick
// SCAN  | evaluating channel idx, one channel per cycle, CH_NUM cycles
module cb_io_filter_sched #(
  parameter int CH_NUM      = 8,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_CNT = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic [CH_NUM-1:0] opt_i,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [CH_NUM-1:0] filter_opt_o,
  output logic              irq_o
);

  localparam int IDX_W = $clog2(CH_NUM);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  thr_s;
  logic [CNT_W-1:0]  cnt [CH_NUM];
  logic [CH_NUM-1:0] sync1, sync2;

  logic              ctrl_en;
  logic [CNT_W-1:0]  thresh_q;
  logic [CH_NUM-1:0] chen_q;
  logic [CH_NUM-1:0] rise_q, fall_q;
  logic              ovr_q;
  logic [31:0]       mask_q;

  logic              sel_sync, sel_filt, sel_chen, mismatch, accept, ovr_set;
  logic [CNT_W-1:0]  sel_cnt, thr_e;
  logic [CNT_W:0]    cnt_inc;
  logic [CH_NUM-1:0] rise_set, fall_set;
  logic [31:0]       rd_mux;

  // Two-flop synchroniser for the raw asynchronous inputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= opt_i;
      sync2 <= sync1;
    end
  end

  // Shared channel datapath: select the channel under scan and decide its step
  always_comb begin
    sel_sync = sync2[idx];
    sel_filt = filter_opt_o[idx];
    sel_chen = chen_q[idx];
    sel_cnt  = cnt[idx];
    thr_e    = (thr_s == '0) ? CNT_W'(1) : thr_s;
    cnt_inc  = {1'b0, sel_cnt} + (CNT_W+1)'(1);
    mismatch = sel_sync != sel_filt;
    accept   = (state == SCAN) && sel_chen && mismatch && (cnt_inc >= {1'b0, thr_e});
    rise_set = '0;
    fall_set = '0;
    if (accept) begin
      if (sel_sync) rise_set[idx] = 1'b1;
      else          fall_set[idx] = 1'b1;
    end
    ovr_set  = (state == SCAN) && tick_i;
  end

  // Scan FSM with per-channel counter and filtered-level updates
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      thr_s        <= CNT_W'(DEFAULT_CNT);
      filter_opt_o <= '0;
      for (int k = 0; k < CH_NUM; k++) cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en && tick_i) begin
            thr_s <= thresh_q;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!sel_chen || !mismatch) begin
            cnt[idx] <= '0;
          end else if (accept) begin
            filter_opt_o[idx] <= sel_sync;
            cnt[idx]          <= '0;
          end else begin
            cnt[idx] <= cnt_inc[CNT_W-1:0];
          end
          if (idx == IDX_W'(CH_NUM - 1)) state <= IDLE;
          else                           idx   <= idx + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux; unused bits return zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux = {31'b0, ctrl_en};
      3'd1: rd_mux = 32'(thresh_q);
      3'd2: rd_mux = 32'(chen_q);
      3'd3: rd_mux = 32'(filter_opt_o);
      3'd4: rd_mux = 32'(rise_q);
      3'd5: rd_mux = 32'(fall_q);
      3'd6: rd_mux = mask_q;
      3'd7: rd_mux = {31'b0, ovr_q};
      default: rd_mux = '0;
    endcase
  end

  // Register file: config writes, W1C flags (hardware set wins), registered read data
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ctrl_en      <= 1'b1;
      thresh_q     <= CNT_W'(DEFAULT_CNT);
      chen_q       <= '1;
      rise_q       <= '0;
      fall_q       <= '0;
      ovr_q        <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (avs_write && avs_address == 3'd0) ctrl_en  <= avs_writedata[0];
      if (avs_write && avs_address == 3'd1) thresh_q <= avs_writedata[CNT_W-1:0];
      if (avs_write && avs_address == 3'd2) chen_q   <= avs_writedata[CH_NUM-1:0];
      rise_q <= (rise_q & ~((avs_write && avs_address == 3'd4) ? avs_writedata[CH_NUM-1:0] : '0))
                | rise_set;
      fall_q <= (fall_q & ~((avs_write && avs_address == 3'd5) ? avs_writedata[CH_NUM-1:0] : '0))
                | fall_set;
      ovr_q  <= (ovr_q & ~(avs_write && avs_address == 3'd7 && avs_writedata[0])) | ovr_set;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

`ifdef CB_IO_FILTER_SCHED_IRQ_EN
  // Interrupt mask register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                   mask_q <= '0;
    else if (avs_write && avs_address == 3'd6) mask_q <= avs_writedata;
  end

  // Registered level interrupt, one cycle behind the flags
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= (|((rise_q | fall_q) & mask_q[CH_NUM-1:0])) | (ovr_q & mask_q[31]);
  end
`else
  logic unused_wd;
  assign unused_wd = ^avs_writedata;
  assign mask_q    = '0;
  assign irq_o     = 1'b0;
`endif

endmodule

// File: doc/cb_io_filter_sched.md
# cb_io_filter_sched

Time-multiplexed debounce scheduler for CH_NUM photoelectric IO inputs on the NIOS II platform. A single compare/increment datapath is shared round-robin across all channels on each filter sample tick, with per-channel counters held in a register array. A NIOS-facing Avalon-MM slave configures the threshold and the channel enables, and exposes the filtered levels, the edge flags and an interrupt.

## Interface
Parameters:
- CH_NUM, 8: number of channels; legal range 2..32.
- CNT_W, 16: counter and threshold width.
- DEFAULT_CNT, 8: threshold value loaded at reset.

Ports:
- sys_clk  in  1  single clock for the whole block.
- rst  in  1  reset; asynchronous, active-high.
- tick_i  in  1  filter sample strobe; one-cycle pulse.
- opt_i  in  CH_NUM  raw asynchronous IO inputs.
- avs_address  in  3  register word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data; valid 1 cycle after avs_read.
- filter_opt_o  out  CH_NUM  filtered levels.
- irq_o  out  1  level interrupt.

## Operation
- Input synchronisation: opt_i passes through a 2-flop synchroniser per bit, giving sync[k].
- FSM states:
  - IDLE: with CTRL.en=1 and tick_i=1, latch THRESH into the shadow register thr_s, set idx=0, and go to SCAN. With CTRL.en=0, tick_i is ignored and the FSM stays in IDLE.
  - SCAN: process channel idx each cycle. idx increments on each SCAN cycle. When idx=CH_NUM-1, go to IDLE on the next cycle.
- Channel step when CH_EN[k]=1:
  - sync[k]==filter_opt_o[k]: cnt[k] is cleared to 0.
  - Mismatch and cnt[k]+1 >= thr_e: filter_opt_o[k] takes the value of sync[k] and cnt[k] is cleared to 0. A 0→1 change sets RISE[k]; a 1→0 change sets FALL[k].
  - Any other mismatch: cnt[k] is incremented by 1.
- Effective threshold: thr_e = max(thr_s, 1). A threshold of N therefore means N consecutive mismatching ticks are needed to accept a change.
- Counter width: cnt[k] never exceeds thr_e-1 and never wraps.
- Channel step when CH_EN[k]=0: cnt[k] is cleared to 0, filter_opt_o[k] holds, and no flags are set.
- Overrun: a tick_i during SCAN sets OVR (sticky bit). That tick is dropped.

Register map (word addresses):
- 0 CTRL: bit0 en. Reset value 1.
- 1 THRESH: bits [CNT_W-1:0]. Reset value DEFAULT_CNT.
- 2 CH_EN: bits [CH_NUM-1:0]. Reset value all ones.
- 3 STATUS: read-only, returns filter_opt_o.
- 4 RISE: write-1-to-clear.
- 5 FALL: write-1-to-clear.
- 6 IRQ_MASK: reset value 0.
- 7 OVR: bit0, write-1-to-clear.
- Unused bits read 0.
- Writes to address 3 are ignored.
- If a W1C clear and a hardware set hit the same bit in the same cycle, the set wins.

## Timing
- Reset values: filter_opt_o=0, every cnt=0, RISE=FALL=OVR=0, irq_o=0, avs_readdata=0, FSM in IDLE.
- Reset asserted mid-scan aborts the scan immediately and all state returns to the reset values.
- Tick accepted in cycle T: channel k is evaluated in cycle T+1+k.
- filter_opt_o[k], RISE[k] and FALL[k] update at T+2+k.
- Scan length: CH_NUM cycles. A tick arriving in the cycle after the last SCAN cycle is accepted.
- Minimum tick period is CH_NUM+1 cycles; a shorter period produces an overrun.
- Input-to-output latency: 2 synchroniser cycles plus scan-slot delay.
- THRESH writes take effect at the next scan start and never apply mid-scan.
- CH_EN and CTRL writes take effect in the cycle after the write.
- irq_o is registered: irq_o = |((RISE|FALL)&IRQ_MASK) | (OVR & IRQ_MASK[31]). It follows a flag change by 1 cycle.
- A read issued while a flag is being set returns the pre-update value.

## Configuration
- CB_IO_FILTER_SCHED_IRQ_EN defined: IRQ_MASK register and irq_o logic are present as described above.
- CB_IO_FILTER_SCHED_IRQ_EN undefined:
  - irq_o is tied to 0.
  - IRQ_MASK reads 0 and writes to it are ignored.
  - RISE, FALL and OVR are still maintained for polling.

## Test plan
- Reset, then opt_i=8'h01 held, THRESH=3, ticks every 20 cycles:
  - Before tick 3, filter_opt_o stays 8'h00.
  - After the 3rd tick's ch0 slot, filter_opt_o=8'h01 and RISE=8'h01.
- THRESH=4; ch2 glitches high for 2 ticks, then low:
  - filter_opt_o[2] stays 0, RISE stays 0, and cnt[2] returns to 0.
- Ticks 5 cycles apart with CH_NUM=8:
  - OVR=1 and the second tick is dropped; the scan completes in 8 cycles.
  - Write 1 to address 7 → OVR=0.
- CH_EN=8'hFE; ch0 toggles for 10 ticks:
  - filter_opt_o[0] holds and RISE[0]=FALL[0]=0.
  - Other channels still filter normally.
- With IRQ_EN defined, IRQ_MASK=8'h10, ch4 falls after being high (THRESH=1):
  - FALL[4]=1 and irq_o=1 one cycle later.
  - Write 8'h10 to address 5 → FALL[4]=0 and irq_o=0 after 1 cycle.
- rst asserted mid-scan (idx=3):
  - All outputs return to 0 immediately and the FSM is in IDLE.
  - THRESH reads DEFAULT_CNT.
